// File: rtl/redmule_tcdm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : redmule_tcdm_arbiter
// Brief    : Shares MP TCDM banks between the core data port and the wide
//            RedMulE HWPE port, with lock-until-granted and core anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module redmule_tcdm_arbiter #(
    parameter int unsigned MP         = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               core_req_i,
    output logic               core_gnt_o,
    input  logic [31:0]        core_add_i,
    input  logic               core_wen_i,
    input  logic [3:0]         core_be_i,
    input  logic [31:0]        core_data_i,
    output logic [31:0]        core_r_data_o,
    output logic               core_r_valid_o,

    input  logic               hwpe_req_i,
    output logic               hwpe_gnt_o,
    input  logic [31:0]        hwpe_add_i,
    input  logic               hwpe_wen_i,
    input  logic [MP*4-1:0]    hwpe_be_i,
    input  logic [MP*32-1:0]   hwpe_data_i,
    output logic [MP*32-1:0]   hwpe_r_data_o,
    output logic               hwpe_r_valid_o,

    output logic [MP-1:0]      mem_req_o,
    output logic [MP-1:0]      mem_wen_o,
    output logic [MP*32-1:0]   mem_add_o,
    output logic [MP*32-1:0]   mem_data_o,
    output logic [MP*4-1:0]    mem_be_o,
    input  logic [MP-1:0]      mem_gnt_i,
    input  logic [MP-1:0]      mem_r_valid_i,
    input  logic [MP*32-1:0]   mem_r_data_i
);

    localparam int unsigned BW = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        LOCK_HWPE = 2'd1,
        LOCK_CORE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   starve_q;
    logic [BW-1:0]   bank;
    logic            hwpe_sel;
    logic            core_sel;
    logic            hwpe_all_gnt;
    logic            core_bank_gnt;

    logic            tag_valid_q;
    logic            tag_hwpe_q;
    logic [BW-1:0]   tag_bank_q;
    logic [31:0]     rdata_bank [MP];

    generate
        if (MP == 1) begin : g_bank_single
            assign bank = '0;
        end else begin : g_bank_addr
            assign bank = core_add_i[2 +: BW];
        end
    endgenerate

    assign hwpe_all_gnt  = &mem_gnt_i;
    assign core_bank_gnt = mem_gnt_i[bank];

    // Arbitration: decides who is presented this cycle and whether a lock is held.
    always_comb begin
        state_d  = state_q;
        hwpe_sel = 1'b0;
        core_sel = 1'b0;
        case (state_q)
            FREE: begin
                if (hwpe_req_i && (starve_q < STARVE_LIM)) begin
                    hwpe_sel = 1'b1;
                    if (!hwpe_all_gnt) begin
                        state_d = LOCK_HWPE;
                    end
                end else if (core_req_i) begin
                    core_sel = 1'b1;
                    if (!core_bank_gnt) begin
                        state_d = LOCK_CORE;
                    end
                end
            end
            LOCK_HWPE: begin
                if (hwpe_req_i) begin
                    hwpe_sel = 1'b1;
                    if (hwpe_all_gnt) begin
                        state_d = FREE;
                    end
                end else begin
                    state_d = FREE;
                end
            end
            LOCK_CORE: begin
                if (core_req_i) begin
                    core_sel = 1'b1;
                    if (core_bank_gnt) begin
                        state_d = FREE;
                    end
                end else begin
                    state_d = FREE;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    assign hwpe_gnt_o = hwpe_sel & hwpe_all_gnt;
    assign core_gnt_o = core_sel & core_bank_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts consecutive denied core cycles; saturates so the core wins the next FREE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else if (core_req_i && !core_gnt_o) begin
            if (starve_q != STARVE_LIM) begin
                starve_q <= starve_q + SW'(1);
            end
        end else begin
            starve_q <= '0;
        end
    end

    generate
        for (genvar i = 0; i < MP; i++) begin : g_bank
            logic core_hit;
            assign core_hit = core_sel && (bank == BW'(i));

            assign mem_req_o[i] = hwpe_sel | core_hit;
            assign mem_wen_o[i] = hwpe_sel ? hwpe_wen_i : (core_hit ? core_wen_i : 1'b0);
            assign mem_add_o[32*i +: 32] = hwpe_sel ? (hwpe_add_i + 32'(4 * i))
                                         : (core_hit ? core_add_i : 32'd0);
            assign mem_data_o[32*i +: 32] = hwpe_sel ? hwpe_data_i[32*i +: 32]
                                          : (core_hit ? core_data_i : 32'd0);
            assign mem_be_o[4*i +: 4] = hwpe_sel ? hwpe_be_i[4*i +: 4]
                                      : (core_hit ? core_be_i : 4'd0);

            assign rdata_bank[i] = mem_r_data_i[32*i +: 32];
        end
    endgenerate

    // One tag stage matches the single-cycle memory latency; reset drops in-flight responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_valid_q <= 1'b0;
            tag_hwpe_q  <= 1'b0;
            tag_bank_q  <= '0;
        end else if (hwpe_gnt_o || core_gnt_o) begin
            tag_valid_q <= 1'b1;
            tag_hwpe_q  <= hwpe_gnt_o;
            tag_bank_q  <= bank;
        end else begin
            tag_valid_q <= 1'b0;
        end
    end

    assign core_r_valid_o = tag_valid_q & ~tag_hwpe_q & mem_r_valid_i[tag_bank_q];
    assign core_r_data_o  = core_r_valid_o ? rdata_bank[tag_bank_q] : 32'd0;

    assign hwpe_r_valid_o = tag_valid_q & tag_hwpe_q & (&mem_r_valid_i);
    assign hwpe_r_data_o  = hwpe_r_valid_o ? mem_r_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_redmule_tcdm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_redmule_tcdm_arbiter
// Brief    : Directed self-checking bench for redmule_tcdm_arbiter (MP=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_redmule_tcdm_arbiter;

    localparam int MP = 8;

    logic              clk;
    logic              rst;
    logic              core_req;
    logic              core_gnt;
    logic [31:0]       core_add;
    logic              core_wen;
    logic [3:0]        core_be;
    logic [31:0]       core_data;
    logic [31:0]       core_r_data;
    logic              core_r_valid;
    logic              hwpe_req;
    logic              hwpe_gnt;
    logic [31:0]       hwpe_add;
    logic              hwpe_wen;
    logic [MP*4-1:0]   hwpe_be;
    logic [MP*32-1:0]  hwpe_data;
    logic [MP*32-1:0]  hwpe_r_data;
    logic              hwpe_r_valid;
    logic [MP-1:0]     mem_req;
    logic [MP-1:0]     mem_wen;
    logic [MP*32-1:0]  mem_add;
    logic [MP*32-1:0]  mem_wdata;
    logic [MP*4-1:0]   mem_be;
    logic [MP-1:0]     mem_gnt;
    logic [MP-1:0]     mem_rvalid;
    logic [MP*32-1:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    redmule_tcdm_arbiter #(.MP(MP), .STARVE_MAX(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .core_req_i     (core_req),
        .core_gnt_o     (core_gnt),
        .core_add_i     (core_add),
        .core_wen_i     (core_wen),
        .core_be_i      (core_be),
        .core_data_i    (core_data),
        .core_r_data_o  (core_r_data),
        .core_r_valid_o (core_r_valid),
        .hwpe_req_i     (hwpe_req),
        .hwpe_gnt_o     (hwpe_gnt),
        .hwpe_add_i     (hwpe_add),
        .hwpe_wen_i     (hwpe_wen),
        .hwpe_be_i      (hwpe_be),
        .hwpe_data_i    (hwpe_data),
        .hwpe_r_data_o  (hwpe_r_data),
        .hwpe_r_valid_o (hwpe_r_valid),
        .mem_req_o      (mem_req),
        .mem_wen_o      (mem_wen),
        .mem_add_o      (mem_add),
        .mem_data_o     (mem_wdata),
        .mem_be_o       (mem_be),
        .mem_gnt_i      (mem_gnt),
        .mem_r_valid_i  (mem_rvalid),
        .mem_r_data_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle memory: answers every granted bank with address + 0x1000_0000.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MP; i++) begin
            mem_rvalid[i]          <= mem_req[i] & mem_gnt[i];
            mem_rdata[32*i +: 32]  <= mem_add[32*i +: 32] + 32'h1000_0000;
        end
    end

    function automatic logic [255:0] exp_hwpe(input logic [31:0] a);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = a + 32'(4 * i) + 32'h1000_0000;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        core_req  = 1'b0;
        core_add  = 32'd0;
        core_wen  = 1'b0;
        core_be   = 4'd0;
        core_data = 32'd0;
        hwpe_req  = 1'b0;
        hwpe_add  = 32'd0;
        hwpe_wen  = 1'b0;
        hwpe_be   = '0;
        hwpe_data = '0;
    endtask

    initial begin
        rst     = 1'b1;
        mem_gnt = 8'hFF;
        clear_inputs();
        tick();
        tick();
        settle();
        chk("rst_mem_req",      256'(mem_req),      256'd0);
        chk("rst_core_gnt",     256'(core_gnt),     256'd0);
        chk("rst_hwpe_gnt",     256'(hwpe_gnt),     256'd0);
        chk("rst_core_rvalid",  256'(core_r_valid), 256'd0);
        chk("rst_hwpe_rvalid",  256'(hwpe_r_valid), 256'd0);
        chk("rst_hwpe_rdata",   256'(hwpe_r_data),  256'd0);
        chk("rst_mem_add",      256'(mem_add),      256'd0);
        rst = 1'b0;

        // Core alone: bank 5, bank 0 ungranted.
        tick();
        mem_gnt  = 8'hFE;
        core_req = 1'b1;
        core_add = 32'h1C01_0014;
        core_wen = 1'b1;
        core_be  = 4'hF;
        settle();
        chk("core_mem_req",   256'(mem_req),              256'h20);
        chk("core_gnt",       256'(core_gnt),             256'd1);
        chk("core_add_b5",    256'(mem_add[5*32 +: 32]),  256'h1C01_0014);
        chk("core_wen_b5",    256'(mem_wen[5]),           256'd1);
        chk("core_be_b5",     256'(mem_be[5*4 +: 4]),     256'hF);
        tick();
        clear_inputs();
        mem_gnt = 8'hFF;
        settle();
        chk("core_rvalid",    256'(core_r_valid),         256'd1);
        chk("core_rdata",     256'(core_r_data),          256'h2C01_0014);
        chk("core_no_hwpe_rv",256'(hwpe_r_valid),         256'd0);
        tick();
        chk("core_rvalid_end",256'(core_r_valid),         256'd0);
        chk("core_rdata_end", 256'(core_r_data),          256'd0);

        // HWPE write, bank 7 denied for 2 cycles.
        mem_gnt  = 8'h7F;
        hwpe_req = 1'b1;
        hwpe_add = 32'h1C01_0100;
        hwpe_wen = 1'b0;
        hwpe_be  = 32'hA5C3_F00F;
        for (int i = 0; i < MP; i++) hwpe_data[32*i +: 32] = 32'hD000_0000 + 32'(i);
        settle();
        chk("hw_gnt_c0",      256'(hwpe_gnt),             256'd0);
        chk("hw_mem_req",     256'(mem_req),              256'hFF);
        chk("hw_add_b3",      256'(mem_add[3*32 +: 32]),  256'h1C01_010C);
        chk("hw_data_b2",     256'(mem_wdata[2*32 +: 32]),256'hD000_0002);
        chk("hw_be_b5",       256'(mem_be[5*4 +: 4]),     256'hC);
        chk("hw_wen_all",     256'(mem_wen),              256'd0);
        tick();
        chk("hw_gnt_c1",      256'(hwpe_gnt),             256'd0);
        tick();
        mem_gnt = 8'hFF;
        settle();
        chk("hw_gnt_c2",      256'(hwpe_gnt),             256'd1);
        tick();
        clear_inputs();
        settle();
        chk("hw_w_rvalid",    256'(hwpe_r_valid),         256'd1);
        chk("hw_w_rdata",     256'(hwpe_r_data),          exp_hwpe(32'h1C01_0100));
        chk("hw_w_core_rv",   256'(core_r_valid),         256'd0);

        // Starvation: both request with full grants; core wins the 5th cycle.
        tick();
        hwpe_req = 1'b1;
        hwpe_add = 32'h1C01_0200;
        hwpe_wen = 1'b1;
        core_req = 1'b1;
        core_add = 32'h1C01_0014;
        core_wen = 1'b1;
        core_be  = 4'hF;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("starve_hgnt_%0d", k), 256'(hwpe_gnt), (k == 4) ? 256'd0 : 256'd1);
            chk($sformatf("starve_cgnt_%0d", k), 256'(core_gnt), (k == 4) ? 256'd1 : 256'd0);
            if (k == 4) begin
                chk("starve_mem_req", 256'(mem_req), 256'h20);
            end
            if (k == 5) begin
                chk("starve_core_rv", 256'(core_r_valid), 256'd1);
                chk("starve_hwpe_rv", 256'(hwpe_r_valid), 256'd0);
            end
            @(posedge clk);
        end
        #1;
        clear_inputs();
        settle();

        // Lock hold: core locked on bank 5 while HWPE requests.
        tick();
        mem_gnt  = 8'hDF;
        core_req = 1'b1;
        core_add = 32'h1C01_0014;
        core_wen = 1'b1;
        core_be  = 4'hF;
        settle();
        chk("lock_cgnt_c0",   256'(core_gnt),             256'd0);
        tick();
        hwpe_req = 1'b1;
        hwpe_add = 32'h1C01_0300;
        hwpe_wen = 1'b1;
        settle();
        chk("lock_hgnt_c1",   256'(hwpe_gnt),             256'd0);
        chk("lock_req_c1",    256'(mem_req),              256'h20);
        tick();
        mem_gnt = 8'hFF;
        settle();
        chk("lock_cgnt_c2",   256'(core_gnt),             256'd1);
        chk("lock_hgnt_c2",   256'(hwpe_gnt),             256'd0);
        tick();
        core_req = 1'b0;
        settle();
        chk("lock_hgnt_c3",   256'(hwpe_gnt),             256'd1);
        chk("lock_core_rv",   256'(core_r_valid),         256'd1);
        tick();
        clear_inputs();
        settle();
        chk("lock_hwpe_rv",   256'(hwpe_r_valid),         256'd1);
        chk("lock_hwpe_rd",   256'(hwpe_r_data),          exp_hwpe(32'h1C01_0300));

        // Reset right after an HWPE read grant drops the response.
        tick();
        hwpe_req = 1'b1;
        hwpe_add = 32'h1C01_0400;
        hwpe_wen = 1'b1;
        settle();
        chk("rstx_hgnt",      256'(hwpe_gnt),             256'd1);
        tick();
        rst = 1'b1;
        clear_inputs();
        settle();
        chk("rstx_hwpe_rv",   256'(hwpe_r_valid),         256'd0);
        chk("rstx_hwpe_rd",   256'(hwpe_r_data),          256'd0);
        chk("rstx_mem_req",   256'(mem_req),              256'd0);
        chk("rstx_hgnt_off",  256'(hwpe_gnt),             256'd0);
        chk("rstx_core_rv",   256'(core_r_valid),         256'd0);
        tick();
        rst = 1'b0;

        // Back-to-back HWPE reads.
        tick();
        hwpe_req = 1'b1;
        hwpe_wen = 1'b1;
        hwpe_add = 32'h1C02_0000;
        settle();
        chk("b2b_gnt0",       256'(hwpe_gnt),             256'd1);
        tick();
        hwpe_add = 32'h1C02_0020;
        settle();
        chk("b2b_rv0",        256'(hwpe_r_valid),         256'd1);
        chk("b2b_rd0",        256'(hwpe_r_data),          exp_hwpe(32'h1C02_0000));
        chk("b2b_gnt1",       256'(hwpe_gnt),             256'd1);
        tick();
        hwpe_add = 32'h1C02_0040;
        settle();
        chk("b2b_rv1",        256'(hwpe_r_valid),         256'd1);
        chk("b2b_rd1",        256'(hwpe_r_data),          exp_hwpe(32'h1C02_0020));
        chk("b2b_gnt2",       256'(hwpe_gnt),             256'd1);
        tick();
        clear_inputs();
        settle();
        chk("b2b_rv2",        256'(hwpe_r_valid),         256'd1);
        chk("b2b_rd2",        256'(hwpe_r_data),          exp_hwpe(32'h1C02_0040));
        tick();
        chk("b2b_rv_end",     256'(hwpe_r_valid),         256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/redmule_tcdm_arbiter.md
# redmule_tcdm_arbiter

Shares one bank of MP 32-bit TCDM memory ports between the cluster core's narrow data port and RedMulE's wide HWPE port. HWPE accesses occupy all MP banks in lockstep; core accesses occupy one bank, selected by address. The block arbitrates per transaction, holds the chosen owner until every targeted bank grants, guarantees core forward progress with a starvation counter, and routes the fixed-latency responses back to the requester. It sits between `redmule_complex` and the TCDM interconnect or memory.

## Interface
- `MP`, default 8: number of 32-bit banks; a power of two, 1 or greater.
- `STARVE_MAX`, default 4: number of consecutive denied core cycles before the core is forced to priority.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `core_req_i`, in, 1: core request.
- `core_gnt_o`, out, 1: core grant.
- `core_add_i`, in, 32: byte address of the core access.
- `core_wen_i`, in, 1: 1 = read, 0 = write.
- `core_be_i`, in, 4: core byte enables.
- `core_data_i`, in, 32: core write data.
- `core_r_data_o`, out, 32: core read data.
- `core_r_valid_o`, out, 1: core response valid.
- `hwpe_req_i`, in, 1: HWPE request.
- `hwpe_gnt_o`, out, 1: HWPE grant.
- `hwpe_add_i`, in, 32: HWPE base byte address.
- `hwpe_wen_i`, in, 1: 1 = read, 0 = write.
- `hwpe_be_i`, in, MP*4: HWPE byte enables.
- `hwpe_data_i`, in, MP*32: HWPE write data.
- `hwpe_r_data_o`, out, MP*32: HWPE read data.
- `hwpe_r_valid_o`, out, 1: HWPE response valid.
- `mem_req_o`, `mem_wen_o`, out, MP: per-bank request and read/write select.
- `mem_add_o`, `mem_data_o`, out, MP×32: per-bank address and write data.
- `mem_be_o`, out, MP×4: per-bank byte enables.
- `mem_gnt_i`, `mem_r_valid_i`, in, MP: per-bank grant and response valid.
- `mem_r_data_i`, in, MP×32: per-bank read data.

## Operation
- **Core bank index:** `bank = core_add_i[2 +: log2(MP)]`. When MP = 1 the index is 0.
- **HWPE drive:** bank i gets `hwpe_add_i + 4*i`, `hwpe_be_i[4i+:4]` and `hwpe_data_i[32i+:32]`.
- **Core drive:** only bank `bank` is driven; it gets `core_add_i` unmodified. All other `mem_req_o` bits are 0.
- **FSM states:** FREE, LOCK_HWPE, LOCK_CORE.
- **FREE:**
  - If `hwpe_req_i=1` and `starve_q<STARVE_MAX`, the winner is HWPE.
  - Otherwise, if `core_req_i=1`, the winner is the core.
  - The winner's requests are presented in the same cycle.
  - If the winner is fully granted (HWPE: AND of all `mem_gnt_i`; core: `mem_gnt_i[bank]`), stay in FREE. Otherwise go to LOCK_<winner>.
- **LOCK_x:** present only x's request. Return to FREE on full grant.
  - The requester must hold its request stable until granted.
  - If the requester drops its request, return to FREE; this is a protocol violation with no memory effect.
- **Starvation counter `starve_q`:**
  - Width is $clog2(STARVE_MAX+1) bits; it saturates at STARVE_MAX.
  - It increments each cycle in which `core_req_i=1` and `core_gnt_o=0`.
  - It clears when the core is granted or `core_req_i=0`.
- **Grant outputs:**
  - `hwpe_gnt_o` = HWPE presented & AND(`mem_gnt_i`).
  - `core_gnt_o` = core presented & `mem_gnt_i[bank]`.
- **Response tag:** on each full grant, register `{valid, owner, bank}`; otherwise clear valid.
- **Response routing:**
  - `core_r_valid_o = tag.valid & owner==core & mem_r_valid_i[tag.bank]`, with `core_r_data_o = mem_r_data_i[tag.bank]`.
  - `hwpe_r_valid_o = tag.valid & owner==hwpe & AND(mem_r_valid_i)`, with `hwpe_r_data_o` the concatenation of all banks, bank 0 in the LSBs.
  - Response data outputs are 0 when the corresponding valid is 0.
- **Writes** also produce an r_valid pulse, with the same behaviour as memory.

## Timing
- **Reset values:** all outputs 0; FSM in FREE; `starve_q=0`; tag invalid.
- **Reset mid-transaction:** in-flight responses are dropped (no r_valid pulse), and locks are released.
- **Request path:** grants and `mem_*` request outputs are combinational from the inputs and the state. No request-path register; zero added cycles.
- **Response latency:** exactly 1 cycle after grant, matching the memory latency. Back-to-back grants give back-to-back responses; one tag stage suffices.
- **Simultaneous requests in FREE:** HWPE wins unless `starve_q==STARVE_MAX`, in which case the core wins. The counter clears on that core grant.
- **In LOCK_x,** the other requester's request does not preempt x, even when the counter is saturated.

## Test plan
- **Core alone:** MP=8, core read at 0x1C010014 with bank 0 ungranted → `mem_req_o=8'b0010_0000` (bank 5). `core_gnt_o=1` in the same cycle. Next cycle `core_r_valid_o=1` with bank-5 data.
- **HWPE write, partial grant:** write at 0x1C010100 with banks 0–6 granted and bank 7 denied for 2 cycles → FSM enters LOCK_HWPE. `hwpe_gnt_o=0` for 2 cycles, then 1. Bank 3 address is 0x1C01010C.
- **Starvation:** HWPE and core request continuously with full grants; STARVE_MAX=4 → HWPE granted 4 cycles, core granted on the 5th, then HWPE again.
- **Lock hold:** core locked with its bank denied while HWPE requests → `hwpe_gnt_o=0` until the core is granted.
- **Reset after an HWPE read grant:** assert `rst_i` before the response → no `hwpe_r_valid_o`, all outputs 0.
- **Back-to-back HWPE reads,** 3 consecutive grants → 3 consecutive `hwpe_r_valid_o` pulses, each with the correct 256-bit data.
